// File: rtl/srl_pattern_loader.sv
// Loads a fixed pattern into an SRLC32E-style shift register, then sweeps its tap
// address and compares every tap against the pattern, keeping sticky status.
//  state | meaning
//  IDLE  | waiting for start after reset
//  LOAD  | shifting PATTERN[L-1] .. PATTERN[0] into the SRL
//  GAP   | one cycle so the final shift lands before the first tap sample
//  READ  | stepping srl_a 0 .. L-1 and comparing srl_q
//  DONE  | status valid and held until the next start
module srl_pattern_loader #(
    parameter logic [255:0] PATTERN    = 256'hFE1AB3FE7610D3D205D9A526C103C40F6477E986F53C53FA663A9CE45E851D30,
    parameter int           SRL_LENGTH = 32,
    localparam int          SRL_BITS   = $clog2(SRL_LENGTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                start,
    output logic                srl_sh,
    output logic                srl_d,
    output logic [SRL_BITS-1:0] srl_a,
    input  logic                srl_q,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [SRL_BITS:0]   err_cnt,
    output logic [SRL_BITS-1:0] first_err_adr
);

    localparam logic [SRL_BITS-1:0] LAST_ADR = SRL_BITS'(SRL_LENGTH - 1);
    localparam logic [SRL_BITS:0]   ERR_MAX  = (SRL_BITS + 1)'(SRL_LENGTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_READ,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [SRL_BITS-1:0] ld_cnt;
    logic                launch;
    logic                read_step;
    logic                miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        read_step = 1'b0;
        miss      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ce && start) begin
                    state_d = S_LOAD;
                    launch  = 1'b1;
                end
            end
            S_LOAD: begin
                if (ce && (ld_cnt == '0)) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (ce) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                read_step = ce;
                miss      = ce && (srl_q != PATTERN[srl_a]);
                if (ce && (srl_a == LAST_ADR)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_LOAD) || (state_q == S_GAP) || (state_q == S_READ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srl_sh        <= 1'b0;
            srl_d         <= 1'b0;
            srl_a         <= '0;
            ld_cnt        <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_cnt       <= '0;
            first_err_adr <= '0;
        end else begin
            // The strobe drops in any cycle ce is low so the SRL never double-shifts.
            srl_sh <= ce && (state_q == S_LOAD);

            if (state_q != S_LOAD) begin
                srl_d <= 1'b0;
            end else if (ce) begin
                srl_d <= PATTERN[ld_cnt];
            end

            if (launch) begin
                ld_cnt        <= LAST_ADR;
                done          <= 1'b0;
                error         <= 1'b0;
                err_cnt       <= '0;
                first_err_adr <= '0;
            end

            if (ce && (state_q == S_LOAD) && (ld_cnt != '0)) begin
                ld_cnt <= ld_cnt - 1'b1;
            end

            if (ce && (state_q == S_GAP)) begin
                srl_a <= '0;
            end

            if (read_step) begin
                if (srl_a == LAST_ADR) begin
                    done <= 1'b1;
                end else begin
                    srl_a <= srl_a + 1'b1;
                end
            end

            if (miss) begin
                error <= 1'b1;
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (!error) begin
                    first_err_adr <= srl_a;
                end
            end
        end
    end

endmodule

// File: tb/tb_srl_pattern_loader.sv
// Bench for srl_pattern_loader: behavioural SRL model with read-path fault
// injection, random enable patterns, and a second L=16 instance with a stuck tap.
module tb_srl_pattern_loader;

    localparam logic [255:0] PAT = 256'hFE1AB3FE7610D3D205D9A526C103C40F6477E986F53C53FA663A9CE45E851D30;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        start;
    logic        srl_sh;
    logic        srl_d;
    logic [4:0]  srl_a;
    logic        srl_q;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  err_cnt;
    logic [4:0]  first_err_adr;

    logic        ce16;
    logic        start16;
    logic        srl_sh16;
    logic        srl_d16;
    logic [3:0]  srl_a16;
    logic        busy16;
    logic        done16;
    logic        error16;
    logic [4:0]  err_cnt16;
    logic [3:0]  first16;

    logic [31:0] srl_mem = '0;
    logic [31:0] fault_mask = '0;
    int          sh_cnt = 0;
    int          sh_cnt16 = 0;
    logic        d_log[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    srl_pattern_loader #(.PATTERN(PAT), .SRL_LENGTH(32)) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start),
        .srl_sh(srl_sh), .srl_d(srl_d), .srl_a(srl_a), .srl_q(srl_q),
        .busy(busy), .done(done), .error(error),
        .err_cnt(err_cnt), .first_err_adr(first_err_adr)
    );

    srl_pattern_loader #(.PATTERN(PAT), .SRL_LENGTH(16)) dut16 (
        .clk(clk), .rst(rst), .ce(ce16), .start(start16),
        .srl_sh(srl_sh16), .srl_d(srl_d16), .srl_a(srl_a16), .srl_q(1'b1),
        .busy(busy16), .done(done16), .error(error16),
        .err_cnt(err_cnt16), .first_err_adr(first16)
    );

    // SRLC32E behaviour: shift in at bit 0 on strobe, tap a reads bit a.
    always @(posedge clk) begin
        if (srl_sh) begin
            srl_mem <= {srl_mem[30:0], srl_d};
            sh_cnt  <= sh_cnt + 1;
            d_log.push_back(srl_d);
        end
        if (srl_sh16) sh_cnt16 <= sh_cnt16 + 1;
    end

    assign srl_q = srl_mem[srl_a] ^ fault_mask[srl_a];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ce_mode: 0 = always on, 1 = toggle, 2 = random; poke issues stray starts mid-run.
    task automatic do_run(input string name, input logic [31:0] mask, input int ce_mode, input bit poke);
        int n, cyc, base_sh, base_log, exp_cnt, exp_first;
        logic [31:0] cap;
        logic [31:0] pat32;
        pat32     = PAT[31:0];
        fault_mask = mask;
        exp_cnt   = 0;
        exp_first = 0;
        for (int a = 31; a >= 0; a--) begin
            if (mask[a]) begin
                exp_cnt++;
                exp_first = a;
            end
        end
        base_sh  = sh_cnt;
        base_log = d_log.size();
        @(negedge clk);
        start = 1'b1;
        ce    = 1'b1;
        n     = 0;
        cyc   = 0;
        @(posedge clk);
        n++;
        cyc++;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_entry"}, {busy, done, error, err_cnt, first_err_adr}, {1'b1, 1'b0, 1'b0, 6'd0, 5'd0});
        while (!done && cyc < 2000) begin
            case (ce_mode)
                0:       ce = 1'b1;
                1:       ce = ~ce;
                default: ce = ($urandom_range(0, 3) != 0);
            endcase
            if (poke && (cyc == 5 || cyc == 40)) begin
                ce    = 1'b1;
                start = 1'b1;
            end
            @(posedge clk);
            if (ce) n++;
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        cap = '0;
        for (int i = 0; i < 32; i++) begin
            if (base_log + i < d_log.size()) cap[31 - i] = d_log[base_log + i];
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_latency"}, 64'(n), 64'd66);
        chk({name, "_shifts"}, 64'(sh_cnt - base_sh), 64'd32);
        chk({name, "_order"}, 64'(cap), 64'(pat32));
        chk({name, "_contents"}, 64'(srl_mem), 64'(pat32));
        chk({name, "_status"}, {busy, error, err_cnt, first_err_adr, srl_a},
            {1'b0, (mask != 0), 6'(exp_cnt), 5'(exp_first), 5'd31});
        ce = 1'b1;
        repeat (3) @(negedge clk);
        chk({name, "_hold"}, {done, error, err_cnt, srl_sh}, {1'b1, (mask != 0), 6'(exp_cnt), 1'b0});
    endtask

    initial begin
        int zeros16, lowest16, n16;
        logic [15:0] pat16;
        rst     = 1'b1;
        ce      = 1'b0;
        start   = 1'b0;
        ce16    = 1'b1;
        start16 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset32", {srl_sh, srl_d, srl_a, busy, done, error, err_cnt, first_err_adr}, 64'd0);
        chk("reset16", {srl_sh16, srl_d16, srl_a16, busy16, done16, error16, err_cnt16, first16}, 64'd0);
        rst = 1'b0;

        do_run("basic", 32'h0, 0, 1'b0);
        do_run("inv5_17", (32'h1 << 5) | (32'h1 << 17), 0, 1'b0);
        do_run("ce_toggle", 32'h0, 1, 1'b0);
        do_run("inv_poke", 32'h0000_0100, 0, 1'b1);
        do_run("restart", 32'h0, 0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        ce    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_reset", {srl_sh, srl_d, srl_a, busy, done, error, err_cnt, first_err_adr}, 64'd0);
        @(negedge clk);
        chk("mid_reset_held", {srl_sh, busy, done, error, err_cnt}, 64'd0);
        rst = 1'b0;
        do_run("after_rst", 32'h0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            do_run($sformatf("rand%0d", r), $urandom & $urandom & $urandom, $urandom_range(0, 2), 1'b0);
        end

        pat16    = PAT[15:0];
        zeros16  = 0;
        lowest16 = 0;
        for (int a = 15; a >= 0; a--) begin
            if (!pat16[a]) begin
                zeros16++;
                lowest16 = a;
            end
        end
        @(negedge clk);
        start16 = 1'b1;
        n16     = 0;
        while (n16 == 0 || (!done16 && n16 < 500)) begin
            @(posedge clk);
            n16++;
            @(negedge clk);
            start16 = 1'b0;
        end
        chk("l16_latency", 64'(n16), 64'd34);
        chk("l16_shifts", 64'(sh_cnt16), 64'd16);
        chk("l16_status", {done16, busy16, error16, err_cnt16, first16, srl_a16, srl_d16},
            {1'b1, 1'b0, (zeros16 != 0), 5'(zeros16), 4'(lowest16), 4'd15, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
